// File: rtl/lfsr_pkg.sv
// Shared constants, register map and helpers for the AXI-Lite LFSR peripheral.
package lfsr_pkg;

  localparam logic [31:0] TAPS       = 32'h8020_0003;
  localparam logic [31:0] RESET_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    REG_LFSR  = 2'd0,
    REG_CTRL  = 2'd1,
    REG_SEED  = 2'd2,
    REG_COUNT = 2'd3
  } reg_sel_t;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 32-bit Galois LFSR state with load-over-step priority and an all-zero lock-up guard.
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RESET_SEED;
    else if (load)
      state <= (load_value == '0) ? RESET_SEED : load_value;
    else if (step)
      state <= lfsr_step(state);
  end

endmodule

// File: rtl/lfsr_v1_0.sv
// AXI4-Lite slave exposing the LFSR state, control, seed and read counter registers.
module lfsr_v1_0
  import lfsr_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);

  logic        clk, rst;
  rd_state_t   rd_state, rd_next;
  wr_state_t   wr_state, wr_next;
  reg_sel_t    rd_sel, wr_sel;
  logic        rd_fire, rd_lfsr, wr_fire, lfsr_wr, reload;
  logic        free_run, core_step, core_load;
  logic [31:0] core_value, state, seed, count, rd_mux;
  logic        unused_ok;

  assign clk       = s00_axi_aclk;
  assign rst       = s00_axi_areset;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (s00_axi_arvalid) rd_next = RD_ADDR;
      RD_ADDR: rd_next = s00_axi_arvalid ? RD_DATA : RD_IDLE;
      RD_DATA: if (s00_axi_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) wr_next = WR_ACK;
      WR_ACK:  wr_next = WR_RESP;
      WR_RESP: if (s00_axi_bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  assign s00_axi_arready = (rd_state == RD_ADDR);
  assign s00_axi_rvalid  = (rd_state == RD_DATA);
  assign s00_axi_awready = (wr_state == WR_ACK);
  assign s00_axi_wready  = (wr_state == WR_ACK);
  assign s00_axi_bvalid  = (wr_state == WR_RESP);
  assign s00_axi_bresp   = '0;
  assign s00_axi_rresp   = '0;

  assign rd_fire = (rd_state == RD_ADDR) && s00_axi_arvalid;
  assign rd_lfsr = rd_fire && (rd_sel == REG_LFSR);
  assign wr_fire = (wr_state == WR_ACK);
  assign wr_sel  = reg_sel_t'(s00_axi_awaddr[3:2]);
  assign lfsr_wr = wr_fire && (wr_sel == REG_LFSR);
  assign reload  = wr_fire && (wr_sel == REG_CTRL) && s00_axi_wstrb[0] && s00_axi_wdata[1];

  // Loads override stepping inside the core, so a coinciding REG0 read captures the old value only.
  assign core_load  = lfsr_wr || reload;
  assign core_value = lfsr_wr ? apply_strb(state, s00_axi_wdata, s00_axi_wstrb) : seed;
  assign core_step  = free_run || rd_lfsr;

  lfsr_core u_core (
    .clk        (clk),
    .rst        (rst),
    .step       (core_step),
    .load       (core_load),
    .load_value (core_value),
    .state      (state)
  );

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      REG_LFSR:  rd_mux = state;
      REG_CTRL:  rd_mux = {31'b0, free_run};
      REG_SEED:  rd_mux = seed;
      REG_COUNT: rd_mux = count;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel        <= REG_LFSR;
      s00_axi_rdata <= '0;
      free_run      <= 1'b0;
      seed          <= RESET_SEED;
      count         <= '0;
    end else begin
      if (rd_state == RD_IDLE && s00_axi_arvalid)
        rd_sel <= reg_sel_t'(s00_axi_araddr[3:2]);
      if (rd_fire)
        s00_axi_rdata <= rd_mux;
      if (rd_lfsr)
        count <= count + 32'd1;
      if (wr_fire) begin
        case (wr_sel)
          REG_CTRL: if (s00_axi_wstrb[0]) free_run <= s00_axi_wdata[0];
          REG_SEED: seed <= apply_strb(seed, s00_axi_wdata, s00_axi_wstrb);
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_v1_0.sv
// Randomised AXI-Lite bench for lfsr_v1_0 against a register-level reference model.
module tb_lfsr_v1_0;

  localparam logic [31:0] M_TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [31:0] m_st, m_seed, m_cnt;
  logic        m_fr;

  lfsr_v1_0 #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: polynomial arithmetic on the whole word, register map as plain variables.
  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] t;
    t = s / 2;
    if (s % 2 == 1) t = t ^ M_TAPS;
    return t;
  endfunction

  function automatic logic [31:0] m_guard(input logic [31:0] v);
    return (v == 0) ? 32'd1 : v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_st = 32'd1; m_seed = 32'd1; m_cnt = 0; m_fr = 1'b0;
  endtask

  task automatic m_read(input logic [3:0] a, output logic [31:0] e);
    case (a[3:2])
      2'd0: begin e = m_st; m_st = m_step(m_st); m_cnt = m_cnt + 1; end
      2'd1: e = {31'b0, m_fr};
      2'd2: e = m_seed;
      default: e = m_cnt;
    endcase
  endtask

  task automatic m_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[3:2])
      2'd0: m_st = m_guard(m_merge(m_st, d, s));
      2'd1: if (s[0]) begin
              m_fr = d[0];
              if (d[1]) m_st = m_guard(m_seed);
            end
      2'd2: m_seed = m_merge(m_seed, d, s);
      default: ;
    endcase
  endtask

  task automatic axi_read(input logic [3:0] a, input int hold, output logic [31:0] data);
    int n;
    data = '0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!arready && n < 20);
    if (!arready) begin
      check("ar_timeout", 32'd0, 32'd1);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rd_latency", {31'b0, rvalid}, 32'd1);
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      check("r_timeout", 32'd0, 32'd1);
      return;
    end
    data = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("rd_hold_valid", {31'b0, rvalid}, 32'd1);
      check("rd_hold_data", rdata, data);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output int c);
    int n;
    c = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(awready && wready) && n < 20);
    if (!(awready && wready)) begin
      check("aw_timeout", 32'd0, 32'd1);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      check("b_timeout", 32'd0, 32'd1);
      return;
    end
    c = cyc;
    if (bresp != 2'b00) check("bresp", {30'b0, bresp}, 32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input int hold, input string tag, output logic [31:0] got);
    logic [31:0] e;
    axi_read(a, hold, got);
    m_read(a, e);
    check(tag, got, e);
  endtask

  task automatic wr_do(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int c;
    axi_write(a, d, s, c);
    m_write(a, d, s);
  endtask

  initial begin
    logic [31:0] d, d1, e, wv;
    int c1, c2, n;

    m_reset();
    #23;
    check("rst_flags", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", {28'b0, bresp, rresp}, 32'd0);
    rst = 1'b0;

    rd_chk(4'h0, 0, "rd0_first", d);  check("rd0_first_const", d, 32'h0000_0001);
    rd_chk(4'h0, 0, "rd0_second", d); check("rd0_second_const", d, 32'h8020_0003);
    rd_chk(4'hC, 0, "count_2", d);    check("count_2_const", d, 32'd2);
    rd_chk(4'h1, 0, "rd_byte1", d);   check("rd_byte1_const", d, 32'hC030_0002);
    rd_chk(4'h2, 0, "rd_byte2", d);   check("rd_byte2_const", d, 32'h6018_0001);
    rd_chk(4'h3, 0, "rd_byte3", d);   check("rd_byte3_const", d, 32'hB02C_0003);

    wr_do(4'h8, 32'h1234_5678, 4'hF);
    wr_do(4'h4, 32'h0000_0002, 4'hF);
    rd_chk(4'h4, 0, "ctrl_readback", d);
    rd_chk(4'h0, 0, "reload", d);     check("reload_const", d, 32'h1234_5678);
    wr_do(4'h0, 32'h0, 4'hF);
    rd_chk(4'h0, 0, "zero_guard", d); check("zero_guard_const", d, 32'h0000_0001);

    rd_chk(4'hC, 0, "count_pre_hold", d1);
    rd_chk(4'h0, 5, "rd_hold", d);
    rd_chk(4'hC, 0, "count_post_hold", d);
    check("count_once", d - d1, 32'd1);
    rd_chk(4'h0, 0, "after_hold", d);

    axi_write(4'h4, 32'h1, 4'hF, c1);
    m_write(4'h4, 32'h1, 4'hF);
    repeat (10) @(posedge clk);
    axi_write(4'h4, 32'h0, 4'hF, c2);
    m_write(4'h4, 32'h0, 4'hF);
    for (int i = 0; i < c2 - c1; i++) m_st = m_step(m_st);
    rd_chk(4'h0, 0, "free_run", d);

    wr_do(4'hC, 32'hDEAD_BEEF, 4'hF);
    rd_chk(4'hC, 0, "count_ro", d);

    wv = $urandom;
    fork
      axi_read(4'h0, 0, d1);
      axi_write(4'h0, wv, 4'hF, c1);
    join
    e = m_st; m_st = m_guard(wv); m_cnt = m_cnt + 1;
    check("simul_rd_old", d1, e);
    rd_chk(4'h0, 0, "simul_wr_wins", d);

    for (int k = 0; k < 60; k++) begin
      logic [3:0] a, s;
      logic [31:0] v;
      a = 4'($urandom_range(0, 15));
      v = $urandom;
      s = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0, 1: rd_chk(a, int'($urandom_range(0, 3)), "rand_rd", d);
        default: begin
          if (a[3:2] == 2'd1) begin v = v & 32'h2; s = 4'hF; end
          if ($urandom_range(0, 7) == 0) v = 32'h0;
          wr_do(a, v, s);
        end
      endcase
    end

    @(posedge clk); #1;
    araddr = 4'h0; arvalid = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    arvalid = 1'b0;
    check("mid_rvalid_seen", {31'b0, rvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_flags", {30'b0, rvalid, arready}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    m_reset();
    rd_chk(4'h0, 0, "post_rst", d); check("post_rst_const", d, 32'h0000_0001);
    rd_chk(4'hC, 0, "post_rst_count", d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
